multilevel_carrier_gen: RTL and testbench

//   Generates N_CARRIERS level-shifted triangular PWM carriers for an (N_CARRIERS+1)-level

---
 rtl/multilevel_carrier_gen_if.sv | 26 ++
 rtl/multilevel_carrier_gen.sv | 128 ++++++++++++
 tb/tb_multilevel_carrier_gen.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multilevel_carrier_gen_if.sv
// Carrier generator control/status bundle: enable and shadow config in, carriers and sync pulses out.
// master = controller/modulator side, slave = carrier generator.
interface multilevel_carrier_gen_if #(
    parameter int N_CARRIERS    = 4,
    parameter int CARRIER_WIDTH = 16,
    parameter int PERIOD_WIDTH  = 16
);
    logic                                enable;
    logic [PERIOD_WIDTH-1:0]             period_in;
    logic [1:0]                          mode_in;
    logic [N_CARRIERS*CARRIER_WIDTH-1:0] carriers;
    logic                                sync_valley;
    logic                                sync_peak;
    logic [PERIOD_WIDTH-1:0]             active_p;
    logic                                cfg_err;

    modport master (
        output enable, period_in, mode_in,
        input  carriers, sync_valley, sync_peak, active_p, cfg_err
    );

    modport slave (
        input  enable, period_in, mode_in,
        output carriers, sync_valley, sync_peak, active_p, cfg_err
    );
endinterface

// File: rtl/multilevel_carrier_gen.sv
// Level-shifted triangular carriers (PD/POD/APOD) for an (N+1)-level inverter, config applied at valleys.
// Latency: one register stage; all outputs aligned, a valley is shown the cycle after enable is sampled high.
// Backpressure: none; free-running while enable is high, parked at the valley while low.
module multilevel_carrier_gen #(
    parameter int N_CARRIERS     = 4,
    parameter int CARRIER_WIDTH  = 16,
    parameter int PERIOD_WIDTH   = 16,
    parameter int PERIOD_DEFAULT = 10000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multilevel_carrier_gen_if.slave bus
);
    localparam int CW  = CARRIER_WIDTH;
    localparam int PW  = PERIOD_WIDTH;
    localparam int FW0 = PW + $clog2(N_CARRIERS) + 1;
    localparam int FW  = (FW0 > CW + 1) ? FW0 : CW + 1;
    localparam logic [PW-1:0] P_RST = PW'(PERIOD_DEFAULT);

    typedef enum logic [1:0] {
        MODE_PD   = 2'b00,
        MODE_POD  = 2'b01,
        MODE_APOD = 2'b10,
        MODE_RSV  = 2'b11
    } mode_t;

    logic [PW-1:0]            t_q, t_n;
    logic [PW-1:0]            p_q, p_n;
    logic                     up_q, up_n;
    logic                     run_q;
    mode_t                    mode_q, mode_n;
    logic                     valley_n, peak_n, err_n;
    logic                     valley_q, peak_q, err_q;
    logic [N_CARRIERS*CW-1:0] car_n, car_q;
    logic [FW-1:0]            span;
    logic                     reject;

    // Band k sits on k*P; inverted bands run P-t so they fall while the others rise.
    function automatic logic [N_CARRIERS*CW-1:0] band_pack(
        input logic [PW-1:0] p,
        input logic [PW-1:0] t,
        input mode_t         m
    );
        logic [N_CARRIERS*CW-1:0] r;
        logic [FW-1:0]            v;
        logic                     u;
        r = '0;
        for (int k = 0; k < N_CARRIERS; k++) begin
            case (m)
                MODE_POD:  u = (k >= N_CARRIERS / 2);
                MODE_APOD: u = ((k % 2) == 1);
                default:   u = 1'b0;
            endcase
            v = FW'(k) * FW'(p) + (u ? (FW'(p) - FW'(t)) : FW'(t));
            r[k*CW +: CW] = v[CW-1:0];
        end
        return r;
    endfunction

    always_comb begin
        span   = FW'(N_CARRIERS) * FW'(bus.period_in);
        reject = (bus.period_in < PW'(2)) || (|span[FW-1:CW]) || (bus.mode_in == MODE_RSV);

        t_n      = t_q;
        up_n     = up_q;
        p_n      = p_q;
        mode_n   = mode_q;
        valley_n = 1'b0;
        peak_n   = 1'b0;
        err_n    = 1'b0;

        if (!bus.enable) begin
            t_n  = '0;
            up_n = 1'b1;
        end else if (!run_q || (!up_q && (t_q == PW'(1)))) begin
            // Valley: the only point where a new period/mode may take effect.
            valley_n = 1'b1;
            t_n      = '0;
            up_n     = 1'b1;
            if (reject) begin
                err_n = 1'b1;
            end else begin
                p_n    = bus.period_in;
                mode_n = mode_t'(bus.mode_in);
            end
        end else if (up_q) begin
            t_n = t_q + PW'(1);
            if (t_n == p_q) begin
                up_n   = 1'b0;
                peak_n = 1'b1;
            end
        end else begin
            t_n = t_q - PW'(1);
        end

        car_n = band_pack(p_n, t_n, mode_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q      <= '0;
            up_q     <= 1'b1;
            run_q    <= 1'b0;
            p_q      <= P_RST;
            mode_q   <= MODE_PD;
            car_q    <= band_pack(P_RST, '0, MODE_PD);
            valley_q <= 1'b0;
            peak_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            t_q      <= t_n;
            up_q     <= up_n;
            run_q    <= bus.enable;
            p_q      <= p_n;
            mode_q   <= mode_n;
            car_q    <= car_n;
            valley_q <= valley_n;
            peak_q   <= peak_n;
            err_q    <= err_n;
        end
    end

    assign bus.carriers    = car_q;
    assign bus.sync_valley = valley_q;
    assign bus.sync_peak   = peak_q;
    assign bus.active_p    = p_q;
    assign bus.cfg_err     = err_q;
endmodule

// File: tb/tb_multilevel_carrier_gen.sv
// Directed bench for multilevel_carrier_gen (N=4, CW=16); a phase-based reference model feeds a scoreboard queue.
module tb_multilevel_carrier_gen;
    localparam int N    = 4;
    localparam int CW   = 16;
    localparam int PW   = 16;
    localparam int PDEF = 10000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multilevel_carrier_gen_if #(.N_CARRIERS(N), .CARRIER_WIDTH(CW), .PERIOD_WIDTH(PW)) bus ();

    multilevel_carrier_gen #(
        .N_CARRIERS(N), .CARRIER_WIDTH(CW), .PERIOD_WIDTH(PW), .PERIOD_DEFAULT(PDEF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [N*CW-1:0] car;
        logic            sv;
        logic            sp;
        logic            err;
        logic [PW-1:0]   ap;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state: phase 0..2P-1 within the carrier period.
    bit m_run;
    int m_ph, m_p, m_mode;
    bit last_valley;

    int          tri4[9] = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
    logic [63:0] rst_car = {16'd30000, 16'd20000, 16'd10000, 16'd0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] car(input int k);
        return bus.carriers[k*CW +: CW];
    endfunction

    function automatic logic [N*CW-1:0] model_car(input int p, input int t, input int mode);
        logic [N*CW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            bit inv;
            int v;
            inv = ((mode == 1) && (k >= N / 2)) || ((mode == 2) && ((k % 2) == 1));
            v   = k * p + (inv ? (p - t) : t);
            r[k*CW +: CW] = CW'(v);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_ph   = 0;
        m_p    = PDEF;
        m_mode = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_car"}, bus.carriers, rst_car);
        check({tag, "_sv"},  bus.sync_valley, 1'b0);
        check({tag, "_sp"},  bus.sync_peak, 1'b0);
        check({tag, "_ap"},  bus.active_p, PW'(PDEF));
        check({tag, "_err"}, bus.cfg_err, 1'b0);
    endtask

    task automatic step();
        exp_t e;
        int   t;
        e = '0;
        t = 0;
        if (!bus.enable) begin
            m_run = 1'b0;
            m_ph  = 0;
        end else begin
            if (!m_run || (m_ph == 2 * m_p - 1)) begin
                m_ph  = 0;
                m_run = 1'b1;
                if ((int'(bus.period_in) < 2) || (N * int'(bus.period_in) > (1 << CW) - 1) ||
                    (bus.mode_in == 2'b11))
                    e.err = 1'b1;
                else begin
                    m_p    = int'(bus.period_in);
                    m_mode = int'(bus.mode_in);
                end
            end else begin
                m_ph++;
            end
            t    = (m_ph <= m_p) ? m_ph : 2 * m_p - m_ph;
            e.sv = (m_ph == 0);
            e.sp = (m_ph == m_p);
        end
        e.ap  = PW'(m_p);
        e.car = model_car(m_p, t, m_mode);
        last_valley = e.sv;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("carriers",    bus.carriers,    e.car);
        check("sync_valley", bus.sync_valley, e.sv);
        check("sync_peak",   bus.sync_peak,   e.sp);
        check("active_p",    bus.active_p,    e.ap);
        check("cfg_err",     bus.cfg_err,     e.err);
    endtask

    task automatic run_to_valley(input string tag);
        for (int i = 0; i < 64; i++) begin
            step();
            if (last_valley) return;
        end
        n_vec++;
        n_err++;
        $error("FAIL %s: no valley within 64 cycles", tag);
    endtask

    initial begin
        bus.enable    = 1'b0;
        bus.period_in = 16'd4;
        bus.mode_in   = 2'b00;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // 1: PD, P=4 triangle and sync timing
        bus.enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            check("t1_c0", car(0), CW'(tri4[i]));
            check("t1_c3", car(3), CW'(12 + tri4[i]));
            check("t1_sv", bus.sync_valley, (i % 8) == 0);
            check("t1_sp", bus.sync_peak, i == 4);
        end

        // 2: POD then APOD band layout
        bus.mode_in = 2'b01;
        run_to_valley("t2_pod");
        check("t2_pod_v_c0", car(0), 16'd0);
        check("t2_pod_v_c1", car(1), 16'd4);
        check("t2_pod_v_c2", car(2), 16'd12);
        check("t2_pod_v_c3", car(3), 16'd16);
        repeat (4) step();
        check("t2_pod_p_sp", bus.sync_peak, 1'b1);
        check("t2_pod_p_c2", car(2), 16'd8);
        check("t2_pod_p_c3", car(3), 16'd12);
        bus.mode_in = 2'b10;
        run_to_valley("t2_apod");
        check("t2_apod_c0", car(0), 16'd0);
        check("t2_apod_c1", car(1), 16'd8);
        check("t2_apod_c2", car(2), 16'd8);
        check("t2_apod_c3", car(3), 16'd16);

        // 3: period written mid-ramp only takes effect at the next valley
        bus.mode_in = 2'b00;
        run_to_valley("t3_sync");
        step();
        step();
        bus.period_in = 16'd6;
        step();
        step();
        check("t3_old_peak", bus.sync_peak, 1'b1);
        check("t3_old_c0", car(0), 16'd4);
        check("t3_old_ap", bus.active_p, 16'd4);
        run_to_valley("t3_new");
        check("t3_new_ap", bus.active_p, 16'd6);
        for (int i = 1; i <= 6; i++) begin
            step();
            check("t3_new_peak", bus.sync_peak, i == 6);
        end
        check("t3_new_c0", car(0), 16'd6);

        // 4: rejected configurations
        bus.period_in = 16'd1;
        run_to_valley("t4_p1");
        check("t4_p1_err", bus.cfg_err, 1'b1);
        check("t4_p1_ap", bus.active_p, 16'd6);
        step();
        check("t4_err_pulse", bus.cfg_err, 1'b0);
        bus.period_in = 16'd20000;
        run_to_valley("t4_big");
        check("t4_big_err", bus.cfg_err, 1'b1);
        check("t4_big_ap", bus.active_p, 16'd6);
        bus.period_in = 16'd4;
        bus.mode_in   = 2'b11;
        run_to_valley("t4_rsv");
        check("t4_rsv_err", bus.cfg_err, 1'b1);
        check("t4_rsv_ap", bus.active_p, 16'd6);
        repeat (6) step();
        check("t4_rsv_c3", car(3), 16'd24);
        bus.mode_in = 2'b00;

        // 5: enable dropped mid-ramp, then restored
        run_to_valley("t5_sync");
        repeat (3) step();
        bus.enable    = 1'b0;
        bus.period_in = 16'd5;
        step();
        check("t5_off_c0", car(0), 16'd0);
        check("t5_off_c1", car(1), 16'd4);
        check("t5_off_c2", car(2), 16'd8);
        check("t5_off_c3", car(3), 16'd12);
        check("t5_off_sv", bus.sync_valley, 1'b0);
        check("t5_off_ap", bus.active_p, 16'd4);
        step();
        bus.period_in = 16'd4;
        bus.enable    = 1'b1;
        step();
        check("t5_on_sv", bus.sync_valley, 1'b1);
        check("t5_on_c0", car(0), 16'd0);

        // 6: asynchronous reset at a peak, released with enable high
        run_to_valley("t6_sync");
        repeat (4) step();
        check("t6_peak", bus.sync_peak, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        model_reset();
        bus.period_in = 16'(PDEF);
        bus.mode_in   = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_c0", car(0), CW'(i));
            check("t6_sv", bus.sync_valley, i == 0);
            check("t6_ap", bus.active_p, PW'(PDEF));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
